// File: rtl/adam_axil_if.sv
// AXI-Lite channel bundle between an xbar master port and a memory endpoint.
// The slave modport is the endpoint's view.
interface adam_axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/adam_axil_to_mem.sv
// AXI-Lite slave to single-port memory request/response bridge.
// One transaction in flight; can be quiesced via pause_req/pause_ack.
//
// state   | meaning
// IDLE    | arbitrate AW+W vs AR, pulse ready, capture payload on handshake
// PAUSED  | quiesced, pause_ack high, no readies
// MEM_REQ | mem_req held with registered payload until mem_gnt
// MEM_RSP | waiting for mem_rvalid
// B_RSP   | b_valid held until b_ready
// R_RSP   | r_valid held until r_ready
module adam_axil_to_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pause_req,
    output logic                    pause_ack,
    adam_axil_if.slave              axi,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_err
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        PAUSED,
        MEM_REQ,
        MEM_RSP,
        B_RSP,
        R_RSP
    } state_e;

    state_e                  state_q;
    logic                    prio_wr_q;
    logic                    is_wr_q;
    logic                    aw_ready_q;
    logic                    w_ready_q;
    logic                    ar_ready_q;
    logic                    b_valid_q;
    logic                    r_valid_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic                    pause_ack_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [STRB_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    logic wr_ok;
    logic rd_ok;
    logic take_wr;
    logic unused_prot;

    assign wr_ok   = axi.aw_valid && axi.w_valid;
    assign rd_ok   = axi.ar_valid;
    assign take_wr = wr_ok && (prio_wr_q || !rd_ok);

    assign unused_prot = ^{axi.aw_prot, axi.ar_prot};

    // Readies are registered one-cycle pulses; the payload is taken on the
    // cycle the pulse is visible, when the master's valid is still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_wr_q   <= 1'b1;
            is_wr_q     <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            ar_ready_q  <= 1'b0;
            b_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            pause_ack_q <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_ready_q) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        is_wr_q    <= 1'b1;
                        addr_q     <= axi.aw_addr;
                        be_q       <= axi.w_strb;
                        wdata_q    <= axi.w_data;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        state_q    <= MEM_REQ;
                    end else if (ar_ready_q) begin
                        ar_ready_q <= 1'b0;
                        is_wr_q    <= 1'b0;
                        addr_q     <= axi.ar_addr;
                        be_q       <= '1;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        state_q    <= MEM_REQ;
                    end else if (pause_req) begin
                        pause_ack_q <= 1'b1;
                        state_q     <= PAUSED;
                    end else if (take_wr) begin
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        prio_wr_q  <= 1'b0;
                    end else if (rd_ok) begin
                        ar_ready_q <= 1'b1;
                        prio_wr_q  <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        pause_ack_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                MEM_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= MEM_RSP;
                    end
                end
                MEM_RSP: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        resp_q  <= mem_err ? 2'b10 : 2'b00;
                        if (is_wr_q) begin
                            b_valid_q <= 1'b1;
                            state_q   <= B_RSP;
                        end else begin
                            r_valid_q <= 1'b1;
                            state_q   <= R_RSP;
                        end
                    end
                end
                B_RSP: begin
                    if (axi.b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                R_RSP: begin
                    if (axi.r_ready) begin
                        r_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.aw_ready = aw_ready_q;
    assign axi.w_ready  = w_ready_q;
    assign axi.ar_ready = ar_ready_q;
    assign axi.b_valid  = b_valid_q;
    assign axi.b_resp   = resp_q;
    assign axi.r_valid  = r_valid_q;
    assign axi.r_resp   = resp_q;
    assign axi.r_data   = rdata_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign pause_ack = pause_ack_q;
endmodule

// File: tb/tb_adam_axil_to_mem.sv
// Directed bench for adam_axil_to_mem: memory responder model plus an
// expected-response queue checked when each B/R response appears.
module tb_adam_axil_to_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause_req = 1'b0;
    logic        pause_ack;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    adam_axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    adam_axil_to_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .axi        (bus),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    exp_t sb[$];
    gnt_t gq[$];

    int n_pass  = 0;
    int n_total = 0;
    int acc_cyc = 0;
    int last_rsp_cyc = 0;

    // memory responder configuration, written only by the stimulus block
    int          cfg_gnt_delay = 0;
    int          cfg_rsp_delay = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_err = 1'b0;

    // responder observations
    int   req_len = 0;
    logic stable_bad = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin : mem_model
        gnt_t cur;
        int   cnt = 0;
        int   req_cyc = 0;
        int   rsp_wait = 0;
        logic pend = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        mem_err = 1'b0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_gnt = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                cnt = 0;
                req_cyc = 0;
                continue;
            end
            if (pend) begin
                if (rsp_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = cfg_rdata;
                    mem_err = cfg_err;
                    pend = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            if (mem_req) begin
                if (req_cyc == 0) begin
                    cur.we = mem_we;
                    cur.addr = mem_addr;
                    cur.be = mem_be;
                    cur.wdata = mem_wdata;
                end else if (cur.we !== mem_we || cur.addr !== mem_addr ||
                             cur.be !== mem_be || cur.wdata !== mem_wdata) begin
                    stable_bad = 1'b1;
                end
                req_cyc++;
                if (cnt == cfg_gnt_delay) begin
                    mem_gnt = 1'b1;
                    pend = 1'b1;
                    rsp_wait = cfg_rsp_delay;
                    gq.push_back(cur);
                    req_len = req_cyc;
                    req_cyc = 0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic wait_aw_accept(input string tag);
        int t = 0;
        while (!bus.aw_ready && t < 50) begin @(negedge clk); t++; end
        chk(tag, {bus.aw_ready, bus.w_ready}, 2'b11);
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b0;
    endtask

    task automatic wait_ar_accept(input string tag);
        int t = 0;
        while (!bus.ar_ready && t < 50) begin @(negedge clk); t++; end
        chk(tag, bus.ar_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        gnt_t g;
        int t = 0;
        while (!(bus.b_valid || bus.r_valid) && t < 300) begin @(negedge clk); t++; end
        if (!(bus.b_valid || bus.r_valid)) begin
            chk({tag, "_timeout"}, 1'b0, 1'b1);
            return;
        end
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b0, 1'b1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_kind"}, bus.b_valid, e.is_wr);
        if (gq.size() == 0) begin
            chk({tag, "_no_grant"}, 1'b0, 1'b1);
        end else begin
            g = gq.pop_front();
            chk({tag, "_mem_we"}, g.we, e.is_wr);
            chk({tag, "_mem_addr"}, g.addr, e.addr);
            chk({tag, "_mem_be"}, g.be, e.be);
            if (e.is_wr) chk({tag, "_mem_wdata"}, g.wdata, e.data);
        end
        if (bus.b_valid) begin
            chk({tag, "_b_resp"}, bus.b_resp, e.resp);
        end else begin
            chk({tag, "_r_data"}, bus.r_data, e.data);
            chk({tag, "_r_resp"}, bus.r_resp, e.resp);
        end
        bus.b_ready = bus.b_valid;
        bus.r_ready = bus.r_valid;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        bus.r_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic bad;
        int   t;
        bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0;  bus.w_strb = '0;  bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // reset held with all request valids asserted
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_outputs", {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid,
                                  bus.r_valid, mem_req, pause_ack}, 7'b0);
        end
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // single write, immediate grant, minimum latency
        cfg_gnt_delay = 0; cfg_rsp_delay = 0; cfg_err = 1'b0; cfg_rdata = 32'h0;
        sb.push_back('{1'b1, 32'h0001_0040, 4'b0101, 32'hDEAD_BEEF, 2'b00});
        bus.aw_addr = 32'h0001_0040; bus.w_data = 32'hDEAD_BEEF; bus.w_strb = 4'b0101;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        wait_aw_accept("wr_accept");
        collect("wr");
        chk("wr_latency", last_rsp_cyc - acc_cyc, 3);

        // read with delayed grant and error response
        cfg_gnt_delay = 4; cfg_rdata = 32'h0000_1234; cfg_err = 1'b1;
        sb.push_back('{1'b0, 32'h0002_0000, 4'hF, 32'h0000_1234, 2'b10});
        bus.ar_addr = 32'h0002_0000; bus.ar_valid = 1'b1;
        wait_ar_accept("rd_accept");
        collect("rd_err");
        chk("rd_req_len", req_len, 5);
        chk("rd_req_stable", stable_bad, 1'b0);

        // both kinds held valid: alternation starting with write
        cfg_gnt_delay = 1; cfg_rdata = 32'hCAFE_0000; cfg_err = 1'b0;
        sb.push_back('{1'b1, 32'h0000_0100, 4'hF, 32'h55AA_55AA, 2'b00});
        sb.push_back('{1'b0, 32'h0000_0200, 4'hF, 32'hCAFE_0000, 2'b00});
        sb.push_back('{1'b1, 32'h0000_0100, 4'hF, 32'h55AA_55AA, 2'b00});
        sb.push_back('{1'b0, 32'h0000_0200, 4'hF, 32'hCAFE_0000, 2'b00});
        bus.aw_addr = 32'h0000_0100; bus.w_data = 32'h55AA_55AA; bus.w_strb = 4'hF;
        bus.ar_addr = 32'h0000_0200;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
        for (int i = 0; i < 4; i++) collect("arb");
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;

        // AW without W is never accepted
        bus.aw_addr = 32'h0000_0300; bus.aw_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad |= bus.aw_ready | bus.w_ready | mem_req;
        end
        chk("aw_alone", bad, 1'b0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;

        // write response backpressure with a read pending
        cfg_gnt_delay = 0; cfg_rdata = 32'h0BAD_0000; cfg_err = 1'b1;
        sb.push_back('{1'b1, 32'h0000_0400, 4'b1100, 32'h1122_3344, 2'b10});
        sb.push_back('{1'b0, 32'h0000_0500, 4'hF, 32'h0BAD_0000, 2'b10});
        bus.aw_addr = 32'h0000_0400; bus.w_data = 32'h1122_3344; bus.w_strb = 4'b1100;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        wait_aw_accept("bp_accept");
        bus.ar_addr = 32'h0000_0500; bus.ar_valid = 1'b1;
        t = 0;
        while (!bus.b_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_b_valid", bus.b_valid, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad |= !bus.b_valid | (bus.b_resp !== 2'b10) | bus.ar_ready;
        end
        chk("bp_stable", bad, 1'b0);
        collect("bp_wr");
        wait_ar_accept("bp_rd_accept");
        collect("bp_rd");

        // pause raised while a read waits for its memory response
        cfg_gnt_delay = 0; cfg_rsp_delay = 4; cfg_rdata = 32'h0000_0077; cfg_err = 1'b0;
        sb.push_back('{1'b0, 32'h0000_0600, 4'hF, 32'h0000_0077, 2'b00});
        bus.ar_addr = 32'h0000_0600; bus.ar_valid = 1'b1;
        wait_ar_accept("ps_accept");
        @(negedge clk);
        @(posedge clk); #1;
        pause_req = 1'b1;
        bus.ar_addr = 32'h0000_0700; bus.ar_valid = 1'b1;
        bad = 1'b0;
        t = 0;
        while (!bus.r_valid && t < 50) begin
            @(negedge clk);
            bad |= pause_ack | bus.ar_ready;
            t++;
        end
        chk("ps_no_early_ack", bad, 1'b0);
        collect("ps_rd1");
        t = 0;
        while (!pause_ack && t < 6) begin @(negedge clk); t++; end
        chk("ps_ack", pause_ack, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bad |= bus.ar_ready | !pause_ack | mem_req;
        end
        chk("ps_quiet", bad, 1'b0);
        @(posedge clk); #1;
        pause_req = 1'b0;
        @(negedge clk);
        chk("ps_ack_hold", pause_ack, 1'b1);
        @(negedge clk);
        chk("ps_ack_drop", pause_ack, 1'b0);
        sb.push_back('{1'b0, 32'h0000_0700, 4'hF, 32'h0000_0077, 2'b00});
        wait_ar_accept("ps_rd2_accept");
        collect("ps_rd2");
        chk("sb_drained", sb.size(), 0);
        chk("req_stable_all", stable_bad, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adam_axil_to_mem.md
Name: adam_axil_to_mem

Overview:
AXI-Lite slave endpoint placed directly downstream of one adam_axil_xbar master port. It converts AXI-Lite read and write transactions into a single-port memory request/response interface (SRAM, register file or peripheral core). It serialises traffic to one outstanding transaction and honours the ADAM pause protocol so the subsystem can quiesce it.

Parameters:
ADDR_WIDTH, 32, AXI-Lite and memory address width
DATA_WIDTH, 32, data width; multiple of 8
STRB_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pause_req  in  1  request to quiesce
pause_ack  out  1  block is quiesced
aw_addr, aw_prot  in  ADDR_WIDTH, 3  write address, protection (prot ignored)
aw_valid / aw_ready  in / out  1  AW handshake
w_data, w_strb  in  DATA_WIDTH, STRB_WIDTH  write data, byte strobes
w_valid / w_ready  in / out  1  W handshake
b_resp  out  2  write response
b_valid / b_ready  out / in  1  B handshake
ar_addr, ar_prot  in  ADDR_WIDTH, 3  read address, protection (prot ignored)
ar_valid / ar_ready  in / out  1  AR handshake
r_data, r_resp  out  DATA_WIDTH, 2  read data, response
r_valid / r_ready  out / in  1  R handshake
mem_req / mem_gnt  out / in  1  memory request, grant
mem_we  out  1  1 = write, 0 = read
mem_addr, mem_be, mem_wdata  out  ADDR_WIDTH, STRB_WIDTH, DATA_WIDTH  request payload
mem_rvalid, mem_rdata, mem_err  in  1, DATA_WIDTH, 1  response strobe, read data, error

Behaviour:
- Reset (rst_n low, async): state IDLE. All ready/valid outputs, mem_req, mem_we and pause_ack are 0. Data/resp/addr registers are 0. Priority flag selects write.
- FSM states: IDLE, PAUSED, MEM_REQ, MEM_RSP, B_RSP, R_RSP.
- IDLE:
  - If pause_req is high, go to PAUSED. This takes precedence over pending requests.
  - Otherwise a write is eligible when aw_valid && w_valid; a read when ar_valid.
  - If both are eligible, the priority flag picks one, then the flag toggles to the other kind.
  - If only one is eligible, it is taken and the flag is set to favour the other kind.
  - Acceptance: aw_ready and w_ready pulse together for exactly 1 cycle (or ar_ready for 1 cycle). Payload is registered and the FSM moves to MEM_REQ.
  - AW valid without W valid, or the reverse, is never accepted alone.
- MEM_REQ: mem_req = 1 with the registered payload. mem_we = 1 for write; for read mem_we = 0 and mem_be is all ones. mem_req is held stable until mem_gnt is sampled high, then the FSM goes to MEM_RSP.
- MEM_RSP: wait for mem_rvalid. mem_rvalid may arrive in the cycle after the grant or later, never in the grant cycle. On mem_rvalid, capture mem_rdata and resp (mem_err ? 2'b10 SLVERR : 2'b00 OKAY), then go to B_RSP (write) or R_RSP (read).
- B_RSP / R_RSP: b_valid or r_valid is held with stable payload until b_ready or r_ready, then return to IDLE. No new transaction is accepted before return to IDLE (one outstanding max).
- Minimum latency, handshake edge to response valid: 3 cycles (accept at t0, mem_req at t1 granted, rvalid at t2, b/r_valid at t3).
- PAUSED: pause_ack = 1 and all readies are 0. When pause_req drops, pause_ack deasserts the next cycle and the FSM returns to IDLE.
  - pause_req raised mid-transaction has no effect until the current response handshake completes.
- Ready signals are never asserted while b_valid, r_valid or mem_req is high.
- Reset asserted mid-transaction: immediate return to reset values. In-flight memory responses are discarded, and mem_rvalid is ignored in IDLE.

Test Plan:
- Reset: rst_n low for 5 cycles with aw/w/ar_valid high -> all readies, b_valid, r_valid, mem_req and pause_ack stay 0.
- Write: aw_addr=0x0001_0040, w_data=0xDEADBEEF, w_strb=4'b0101, mem_gnt immediate, rvalid next cycle -> mem_we=1, mem_be=4'b0101, mem_addr=0x0001_0040, b_valid at t3 with b_resp=2'b00.
- Read with error: ar_addr=0x0002_0000, mem_gnt delayed 4 cycles, mem_rdata=0x1234, mem_err=1 -> mem_req stable 5 cycles, r_data=0x1234, r_resp=2'b10.
- Arbitration: AW+W and AR held valid for 4 transactions -> order write, read, write, read. AW valid alone with no W -> never accepted.
- Backpressure: b_ready low for 6 cycles -> b_valid and b_resp stable, ar_ready stays 0 throughout.
- Pause: pause_req raised during MEM_RSP -> pause_ack only after r handshake; when pause_req falls, pause_ack=0 next cycle and a pending read is then accepted.
